// File: rtl/packet_check.sv
// packet_check: compares looped-back AXIS beats with the expected stream and keeps error/framing counters.
module packet_check #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [7:0]   CYCLES_PER_PACKET,
    input  logic [63:0]  PACKET_COUNT,
    input  logic [1:0]   control,
    output logic [3:0]   status,
    output logic [63:0]  packets_rcvd,
    output logic [31:0]  mismatch_beats,
    output logic [31:0]  bit_errors,
    output logic [31:0]  framing_errors,
    input  logic [511:0] AXIS_IN_TDATA,
    input  logic [63:0]  AXIS_IN_TKEEP,
    input  logic         AXIS_IN_TLAST,
    input  logic         AXIS_IN_TVALID,
    output logic         AXIS_IN_TREADY,
    input  logic [511:0] AXIS_EXP_TDATA,
    input  logic         AXIS_EXP_TVALID,
    output logic         AXIS_EXP_TREADY
);
    typedef enum logic {IDLE, CHECK} state_t;
    state_t state_q, state_d;
    logic [7:0] cpp_q, cyc_q;
    logic [63:0] pkt_target_q;
    logic [31:0] tmo_q;
    logic [511:0] s1_diff;
    logic s1_valid, s1_frm, fin_q, done_q, timeout_q, error_q;
    logic check, start_go, accept, frm, last_pkt, tmo_expire;
    logic [9:0] pop;
    logic [32:0] bit_sum;

    assign check = state_q == CHECK;
    assign start_go = !check && control[0];
    assign AXIS_IN_TREADY = check && AXIS_EXP_TVALID;
    assign AXIS_EXP_TREADY = check && AXIS_IN_TVALID;
    assign accept = check && AXIS_IN_TVALID && AXIS_EXP_TVALID;
    assign frm = (AXIS_IN_TLAST != (cyc_q == cpp_q)) || (AXIS_IN_TKEEP != '1);
    assign last_pkt = accept && AXIS_IN_TLAST && (packets_rcvd + 64'd1 == pkt_target_q);
    assign tmo_expire = check && !accept && tmo_q <= 32'd1;
    assign status = {error_q, timeout_q, done_q, control[0] || check || s1_valid};
    assign bit_sum = {1'b0, bit_errors} + {23'd0, pop};

    always_comb begin
        pop = '0;
        for (int i = 0; i < 512; i++)
            pop = pop + {9'd0, s1_diff[i]};
    end

    always_comb begin
        state_d = state_q;
        if (start_go)
            state_d = CHECK;
        else if (check && (control[1] || last_pkt || tmo_expire))
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_diff <= '0;
            s1_frm <= 1'b0;
            fin_q <= 1'b0;
            done_q <= 1'b0;
            timeout_q <= 1'b0;
            error_q <= 1'b0;
            cpp_q <= '0;
            cyc_q <= '0;
            pkt_target_q <= '0;
            tmo_q <= '0;
            packets_rcvd <= '0;
            mismatch_beats <= '0;
            bit_errors <= '0;
            framing_errors <= '0;
        end else begin
            s1_valid <= accept;
            s1_diff <= AXIS_IN_TDATA ^ AXIS_EXP_TDATA;
            s1_frm <= frm;
            fin_q <= last_pkt;
            done_q <= fin_q;
            if (start_go) begin
                timeout_q <= 1'b0;
                error_q <= 1'b0;
                cpp_q <= CYCLES_PER_PACKET;
                cyc_q <= 8'd1;
                pkt_target_q <= PACKET_COUNT;
                tmo_q <= 32'(TIMEOUT_CYCLES);
                packets_rcvd <= '0;
                mismatch_beats <= '0;
                bit_errors <= '0;
                framing_errors <= '0;
            end else begin
                if (accept) begin
                    cyc_q <= AXIS_IN_TLAST ? 8'd1 : cyc_q + 8'd1;
                    tmo_q <= 32'(TIMEOUT_CYCLES);
                    if (AXIS_IN_TLAST)
                        packets_rcvd <= packets_rcvd + 64'd1;
                end else if (check && tmo_q != 32'd0) begin
                    tmo_q <= tmo_q - 32'd1;
                end
                if (tmo_expire)
                    timeout_q <= 1'b1;
                if (s1_valid) begin
                    if (|s1_diff && mismatch_beats != '1)
                        mismatch_beats <= mismatch_beats + 32'd1;
                    bit_errors <= bit_sum[32] ? '1 : bit_sum[31:0];
                    if (s1_frm && framing_errors != '1)
                        framing_errors <= framing_errors + 32'd1;
                    if (|s1_diff || s1_frm)
                        error_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_check.sv
// tb_packet_check: directed runs with a scoreboard of expected end-of-run counters.
module tb_packet_check;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [7:0] cpp = '0;
    logic [63:0] pcount = '0;
    logic [1:0] control = '0;
    logic [3:0] status;
    logic [63:0] packets_rcvd;
    logic [31:0] mismatch_beats, bit_errors, framing_errors;
    logic [511:0] in_tdata = '0, exp_tdata = '0;
    logic [63:0] in_tkeep = '1;
    logic in_tlast = 1'b0, in_tvalid = 1'b0, exp_tvalid = 1'b0;
    logic in_tready, exp_tready;

    typedef struct {
        logic [63:0] pk;
        logic [31:0] mm;
        logic [31:0] be;
        logic [31:0] fe;
        logic err;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int checks = 0, errors = 0, done_cnt = 0;
    int cyc = 1;
    logic [7:0] m_cpp = '0;

    always #5 clk = ~clk;

    always @(negedge clk) if (status[1]) done_cnt++;

    packet_check #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .resetn(resetn),
        .CYCLES_PER_PACKET(cpp),
        .PACKET_COUNT(pcount),
        .control(control),
        .status(status),
        .packets_rcvd(packets_rcvd),
        .mismatch_beats(mismatch_beats),
        .bit_errors(bit_errors),
        .framing_errors(framing_errors),
        .AXIS_IN_TDATA(in_tdata),
        .AXIS_IN_TKEEP(in_tkeep),
        .AXIS_IN_TLAST(in_tlast),
        .AXIS_IN_TVALID(in_tvalid),
        .AXIS_IN_TREADY(in_tready),
        .AXIS_EXP_TDATA(exp_tdata),
        .AXIS_EXP_TVALID(exp_tvalid),
        .AXIS_EXP_TREADY(exp_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] c, input logic [63:0] p, input logic [1:0] ctl);
        cpp = c;
        pcount = p;
        control = ctl;
        tick();
        control = 2'b00;
        cpp = '0;
        pcount = '0;
        m = '{default: '0};
        m_cpp = c;
        cyc = 1;
    endtask

    task automatic beat(input logic [511:0] flip, input logic last, input logic [63:0] keep);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        exp_tdata = d;
        in_tdata = d ^ flip;
        in_tlast = last;
        in_tkeep = keep;
        in_tvalid = 1'b1;
        exp_tvalid = 1'b1;
        @(negedge clk);
        chk("in_tready", 64'(in_tready), 64'(1));
        chk("exp_tready", 64'(exp_tready), 64'(1));
        tick();
        in_tvalid = 1'b0;
        exp_tvalid = 1'b0;
        in_tlast = 1'b0;
        in_tkeep = '1;
        if (flip != '0) m.mm++;
        m.be += 32'($countones(flip));
        if ((last != (cyc == int'(m_cpp))) || keep != '1) m.fe++;
        cyc = last ? 1 : cyc + 1;
        if (last) m.pk++;
        m.err = (m.mm != 0) || (m.fe != 0);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pk"}, packets_rcvd, e.pk);
            chk({tag, "_mm"}, 64'(mismatch_beats), 64'(e.mm));
            chk({tag, "_be"}, 64'(bit_errors), 64'(e.be));
            chk({tag, "_fe"}, 64'(framing_errors), 64'(e.fe));
            chk({tag, "_err"}, 64'(status[3]), 64'(e.err));
        end
    endtask

    task automatic finish_run(input string tag);
        logic got;
        got = 1'b0;
        sb.push_back(m);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = status[1];
        end
        chk({tag, "_done"}, 64'(got), 64'(1));
        compare(tag);
        @(negedge clk);
        chk({tag, "_done1"}, 64'(status[1]), 64'(0));
        chk({tag, "_busy"}, 64'(status[0]), 64'(0));
        tick();
    endtask

    initial begin
        logic [511:0] f;
        int n, dc;
        logic hit;
        repeat (3) tick();
        in_tvalid = 1'b1;
        exp_tvalid = 1'b1;
        @(negedge clk);
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_pk", packets_rcvd, 64'(0));
        chk("rst_mm", 64'(mismatch_beats), 64'(0));
        chk("rst_be", 64'(bit_errors), 64'(0));
        chk("rst_fe", 64'(framing_errors), 64'(0));
        chk("rst_in_tready", 64'(in_tready), 64'(0));
        chk("rst_exp_tready", 64'(exp_tready), 64'(0));
        resetn = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_in_tready", 64'(in_tready), 64'(0));
        chk("idle_exp_tready", 64'(exp_tready), 64'(0));
        tick();
        in_tvalid = 1'b0;
        exp_tvalid = 1'b0;

        start(8'd4, 64'd3, 2'b01);
        for (int b = 0; b < 12; b++) beat('0, b % 4 == 3, '1);
        finish_run("clean");

        start(8'd4, 64'd3, 2'b01);
        for (int b = 0; b < 12; b++) begin
            f = '0;
            if (b == 4) f[$urandom_range(511, 0)] = 1'b1;
            beat(f, b % 4 == 3, '1);
        end
        finish_run("flip1");

        start(8'd4, 64'd1, 2'b01);
        for (int b = 0; b < 4; b++) begin
            f = '0;
            if (b == 0) f = '1;
            if (b == 2) begin
                f[7] = 1'b1;
                f[300] = 1'b1;
                f[511] = 1'b1;
            end
            beat(f, b == 3, '1);
        end
        finish_run("flip515");

        start(8'd4, 64'd2, 2'b01);
        for (int b = 0; b < 3; b++) beat('0, b == 2, '1);
        for (int b = 0; b < 4; b++) beat('0, b == 3, '1);
        finish_run("early_last");

        start(8'd1, 64'd2, 2'b01);
        beat('0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF);
        beat('0, 1'b1, '1);
        finish_run("keep");

        dc = done_cnt;
        start(8'd4, 64'd1, 2'b01);
        in_tvalid = 1'b1;
        exp_tvalid = 1'b0;
        @(negedge clk);
        chk("to_in_tready", 64'(in_tready), 64'(0));
        chk("to_exp_tready", 64'(exp_tready), 64'(1));
        hit = 1'b0;
        n = 1;
        while (!hit && n < 40) begin
            if (n > 1) @(negedge clk);
            hit = status[2];
            if (!hit) n++;
        end
        chk("to_flag", 64'(hit), 64'(1));
        chk("to_window", 64'(n >= 16 && n <= 18), 64'(1));
        chk("to_idle", 64'(exp_tready), 64'(0));
        sb.push_back(m);
        compare("timeout");
        tick();
        in_tvalid = 1'b0;
        tick();
        chk("to_nodone", 64'(done_cnt), 64'(dc));
        chk("to_sticky", 64'(status[2]), 64'(1));

        start(8'd2, 64'd5, 2'b01);
        chk("abort_toclr", 64'(status[2]), 64'(0));
        for (int b = 0; b < 4; b++) beat(b == 1 ? 512'd6 : 512'd0, b % 2 == 1, '1);
        control = 2'b10;
        tick();
        control = 2'b00;
        chk("abort_busy", 64'(status[0]), 64'(0));
        in_tvalid = 1'b1;
        @(negedge clk);
        chk("abort_idle", 64'(exp_tready), 64'(0));
        tick();
        in_tvalid = 1'b0;
        sb.push_back(m);
        compare("abort");
        chk("abort_nodone", 64'(done_cnt), 64'(dc));

        start(8'd2, 64'd1, 2'b11);
        in_tvalid = 1'b1;
        @(negedge clk);
        chk("both_check", 64'(exp_tready), 64'(1));
        sb.push_back(m);
        compare("both");
        tick();
        in_tvalid = 1'b0;
        control = 2'b10;
        tick();
        control = 2'b00;

        start(8'd4, 64'd2, 2'b01);
        beat(512'd1, 1'b0, '1);
        beat('0, 1'b0, '1);
        in_tvalid = 1'b1;
        exp_tvalid = 1'b1;
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("mrst_in_tready", 64'(in_tready), 64'(0));
        chk("mrst_exp_tready", 64'(exp_tready), 64'(0));
        chk("mrst_status", 64'(status), 64'(0));
        m = '{default: '0};
        sb.push_back(m);
        compare("mrst");
        tick();
        in_tvalid = 1'b0;
        exp_tvalid = 1'b0;
        resetn = 1'b1;
        tick();
        start(8'd4, 64'd1, 2'b01);
        for (int b = 0; b < 4; b++) beat('0, b == 3, '1);
        finish_run("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
